// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_pkg;

    localparam int unsigned INST_ADDR_W    = 32;
    localparam int unsigned INST_W         = 32;
    localparam int unsigned IF_QUEUE_DEPTH = 2;

    localparam logic [INST_W-1:0] ZERO_WORD    = '0;
    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;
    localparam logic              RST_ENABLE   = 1'b1;

    // One fetch-queue entry: the byte address and the word read from it.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// if_queue: synchronous FIFO of {pc, inst} entries with a flush input.
// While empty the head output holds the last entry that was presented.
module if_queue
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = IF_QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clr_i,
    input  fetch_entry_t data_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     last_q;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? last_q : mem_q[head_q];

    // Pointer and occupancy update; a flush wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_ONE;
            if (pop_i)  head_d = head_q + PTR_ONE;
            if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
            else if (pop_i && !push_i) count_d = count_q - CNT_ONE;
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; needs no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[tail_q] <= data_i;
    end

    // Remember the presented head so the outputs hold while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) last_q <= '0;
        else if (!empty_o)     last_q <= mem_q[head_q];
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, ROM ce/addr, reset-release flop and the fetch queue.
// Optional IF_PERF_CNT_EN adds push and redirect counters.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4,
    parameter int unsigned QUEUE_DEPTH = IF_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_flush_o,
`endif
    output logic [31:0] id_inst_o
);

    logic         rst_q;
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, full, empty;
    fetch_entry_t push_data, head;

    assign id_valid_o = !empty;
    assign pop        = !empty && id_ready_i;
    assign id_pc_o    = head.pc;
    assign id_inst_o  = head.inst;

    // Fetch decision, ROM drive and next PC; redirect dominates stall and fetch.
    always_comb begin
        push       = !rst_q && !stall_i && !redirect_i && (!full || pop);
        rom_ce_o   = push ? CHIP_ENABLE : CHIP_DISABLE;
        rom_addr_o = push ? pc_q : '0;
        push_data  = '{pc: pc_q, inst: rom_inst_i};
        pc_d       = pc_q;
        if (redirect_i) pc_d = word_align(redirect_pc_i);
        else if (push)  pc_d = pc_q + PC_STEP;
    end

    // Reset-release flop holds off fetching for one edge after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) rst_q <= 1'b1;
        else                   rst_q <= 1'b0;
    end

    // Program counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) pc_q <= RESET_PC;
        else                   pc_q <= pc_d;
    end

    if_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (redirect_i),
        .data_i  (push_data),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    // Free-running event counters, wrapping silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)       fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect_i) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_o = fetch_cnt_q;
    assign perf_flush_o = flush_cnt_q;
`endif

endmodule
